pagerank_iter_sched: RTL and testbench

// - Iteration scheduler and output arbiter for NUM_SCATTER pagerank scatter units (one per graph partition).
// - Starts each iteration: enable plus a next-iteration pulse to all units.
// - Round-robin merges their (node_id, value) streams into the single gather input.
// - Detects end of iteration, waits for gather to drain, repeats up to cfg_max_iter iterations.

---
 rtl/pagerank_pkg.sv | 27 ++
 rtl/pr_rr_arbiter.sv | 46 ++++
 rtl/pagerank_iter_sched.sv | 162 ++++++++++++++++
 tb/tb_pagerank_iter_sched.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pagerank_pkg.sv
// Shared types for the pagerank iteration scheduler: FSM state encoding,
// default datapath widths, the node record and a saturating counter helper.
package pagerank_pkg;

    localparam int DEF_ID_W  = 32;
    localparam int DEF_VAL_W = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        SCATTER = 3'd2,
        DRAIN   = 3'd3,
        NEXT    = 3'd4,
        DONE    = 3'd5
    } sched_state_t;

    typedef struct packed {
        logic [DEF_ID_W-1:0]  id;
        logic [DEF_VAL_W-1:0] value;
    } node_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pr_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// wrapping modulo N. The pointer moves past the winner only on advance,
// so an unaccepted grant is offered again to the same requester.
module pr_rr_arbiter #(
    parameter int N = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr;

    // Rotating priority search starting at the pointer.
    always_comb begin
        logic found;
        grant     = '0;
        grant_idx = ptr;
        found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            automatic int idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

    // Pointer moves to the slot after the unit that just transferred.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (advance) begin
            if (int'(grant_idx) == N - 1)
                ptr <= '0;
            else
                ptr <= grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/pagerank_iter_sched.sv
// Pagerank iteration scheduler and scatter->gather output arbiter.
// Runs up to cfg_max_iter iterations: launch all scatter units, merge their
// streams round-robin into a one-entry output register, wait for every unit
// to report done and for gather to go idle, then repeat.
// Optional build macro PR_SCHED_STATS_EN adds per-iteration transfer and
// stall counters; without it stat_xfers/stat_stalls read 0.
module pagerank_iter_sched #(
    parameter int NUM_SCATTER = 4,
    parameter int ID_W        = pagerank_pkg::DEF_ID_W,
    parameter int VAL_W       = pagerank_pkg::DEF_VAL_W,
    parameter int ITER_W      = 8
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic [ITER_W-1:0]                     cfg_max_iter,
    output logic [NUM_SCATTER-1:0]                sc_enable,
    output logic [NUM_SCATTER-1:0]                sc_next_iter,
    input  logic [NUM_SCATTER-1:0]                sc_valid,
    input  logic [NUM_SCATTER-1:0][ID_W-1:0]      sc_node_id,
    input  logic [NUM_SCATTER-1:0][VAL_W-1:0]     sc_value,
    output logic [NUM_SCATTER-1:0]                sc_ready,
    input  logic [NUM_SCATTER-1:0]                sc_done,
    output logic                                  g_valid,
    input  logic                                  g_ready,
    output logic [ID_W-1:0]                       g_node_id,
    output logic [VAL_W-1:0]                      g_value,
    input  logic                                  gather_idle,
    output logic                                  busy,
    output logic                                  run_done,
    output logic [ITER_W-1:0]                     iter_count,
    output logic [31:0]                           stat_xfers,
    output logic [31:0]                           stat_stalls
);
    import pagerank_pkg::*;

    localparam int IDX_W = (NUM_SCATTER > 1) ? $clog2(NUM_SCATTER) : 1;

    sched_state_t           state, state_nxt;
    logic [NUM_SCATTER-1:0] done_mask;
    logic [ITER_W-1:0]      max_iter;
    logic [ITER_W-1:0]      iter_inc;
    logic [NUM_SCATTER-1:0] arb_req, grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   in_run, start_ok, out_free, xfer, abort_hit;

    assign in_run    = (state == LAUNCH) || (state == SCATTER) ||
                       (state == DRAIN)  || (state == NEXT);
    assign start_ok  = start && !abort && ((state == IDLE) || (state == DONE));
    assign abort_hit = abort && in_run;
    assign iter_inc  = iter_count + 1'b1;

    // Only arbitrate while scattering; the register can take a new entry
    // when empty or when its current entry leaves this cycle.
    assign arb_req   = (state == SCATTER) ? sc_valid : '0;
    assign out_free  = !g_valid || g_ready;
    assign sc_ready  = grant & {NUM_SCATTER{out_free}};
    assign xfer      = |(sc_valid & sc_ready);

    pr_rr_arbiter #(.N(NUM_SCATTER)) u_arb (
        .clock     (clock),
        .reset     (reset),
        .req       (arb_req),
        .advance   (xfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // FSM next state and state-decoded outputs; abort overrides everything.
    always_comb begin
        state_nxt    = state;
        sc_enable    = in_run ? '1 : '0;
        sc_next_iter = (state == LAUNCH) ? '1 : '0;
        busy         = in_run;
        run_done     = (state == DONE);
        case (state)
            IDLE, DONE: if (start_ok) state_nxt = LAUNCH;
            LAUNCH:     state_nxt = SCATTER;
            // Done alone is not enough: a unit may flag done early while
            // still holding data, and the output register must be empty.
            SCATTER:    if ((&done_mask) && !(|sc_valid) && !g_valid)
                            state_nxt = DRAIN;
            DRAIN:      if (gather_idle) state_nxt = NEXT;
            NEXT:       state_nxt = (iter_inc == max_iter) ? DONE : LAUNCH;
            default:    state_nxt = IDLE;
        endcase
        if (abort_hit)
            state_nxt = DONE;
    end

    // State register, run configuration, done tracking and iteration count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            done_mask  <= '0;
            max_iter   <= '0;
            iter_count <= '0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                max_iter   <= (cfg_max_iter == '0) ? ITER_W'(1) : cfg_max_iter;
                iter_count <= '0;
            end
            if (state == LAUNCH)
                done_mask <= '0;
            else if (state == SCATTER)
                done_mask <= done_mask | sc_done;
            if (state == NEXT && !abort)
                iter_count <= iter_inc;
        end
    end

    // One-entry output register toward gather; abort flushes it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            g_valid   <= 1'b0;
            g_node_id <= '0;
            g_value   <= '0;
        end else if (abort_hit) begin
            g_valid <= 1'b0;
        end else if (xfer) begin
            g_valid   <= 1'b1;
            g_node_id <= sc_node_id[grant_idx];
            g_value   <= sc_value[grant_idx];
        end else if (g_ready) begin
            g_valid <= 1'b0;
        end
    end

`ifdef PR_SCHED_STATS_EN
    logic [31:0] xfer_cnt, stall_cnt;

    // Per-iteration counters: cleared at launch, published at iteration end.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            xfer_cnt    <= '0;
            stall_cnt   <= '0;
            stat_xfers  <= '0;
            stat_stalls <= '0;
        end else begin
            if (state == LAUNCH) begin
                xfer_cnt  <= '0;
                stall_cnt <= '0;
            end else if (state == SCATTER) begin
                if (xfer)
                    xfer_cnt <= sat_inc(xfer_cnt);
                if (g_valid && !g_ready)
                    stall_cnt <= sat_inc(stall_cnt);
            end
            if (state == NEXT) begin
                stat_xfers  <= xfer_cnt;
                stat_stalls <= stall_cnt;
            end
        end
    end
`else
    assign stat_xfers  = '0;
    assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_pagerank_iter_sched.sv
// Self-checking bench for pagerank_iter_sched: behavioural scatter units,
// a gather-side scoreboard and a round-robin reference pointer.
module tb_pagerank_iter_sched;
    import pagerank_pkg::*;

    localparam int N      = 4;
    localparam int ID_W   = 32;
    localparam int VAL_W  = 64;
    localparam int ITER_W = 8;

    logic                      clock = 1'b0;
    logic                      reset = 1'b1;
    logic                      start = 1'b0;
    logic                      abort = 1'b0;
    logic [ITER_W-1:0]         cfg_max_iter = '0;
    logic [N-1:0]              sc_enable, sc_next_iter, sc_ready;
    logic [N-1:0]              sc_valid = '0;
    logic [N-1:0][ID_W-1:0]    sc_node_id = '0;
    logic [N-1:0][VAL_W-1:0]   sc_value = '0;
    logic [N-1:0]              sc_done = '0;
    logic                      g_valid;
    logic                      g_ready = 1'b1;
    logic [ID_W-1:0]           g_node_id;
    logic [VAL_W-1:0]          g_value;
    logic                      gather_idle = 1'b1;
    logic                      busy, run_done;
    logic [ITER_W-1:0]         iter_count;
    logic [31:0]               stat_xfers, stat_stalls;

    pagerank_iter_sched #(.NUM_SCATTER(N), .ID_W(ID_W), .VAL_W(VAL_W), .ITER_W(ITER_W)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .cfg_max_iter(cfg_max_iter), .sc_enable(sc_enable), .sc_next_iter(sc_next_iter),
        .sc_valid(sc_valid), .sc_node_id(sc_node_id), .sc_value(sc_value),
        .sc_ready(sc_ready), .sc_done(sc_done), .g_valid(g_valid), .g_ready(g_ready),
        .g_node_id(g_node_id), .g_value(g_value), .gather_idle(gather_idle),
        .busy(busy), .run_done(run_done), .iter_count(iter_count),
        .stat_xfers(stat_xfers), .stat_stalls(stat_stalls)
    );

    always #5 clock = ~clock;

    int           errors = 0;
    int           checks = 0;
    node_t        unit_q[N][$];
    node_t        sb[$];
    int           grant_log[$];
    int           grant_cyc[$];
    logic [N-1:0] xm = '0;
    logic [N-1:0] prev_xm = '0;
    logic [31:0]  prev_id = '0;
    bit           prev_abort = 1'b0;
    int           tb_ptr = 0;
    int           launch_cnt = 0;
    int           rcv_cnt = 0;
    bit           launch_seen = 1'b0;
    bit           auto_mode = 1'b0;
    logic [N-1:0] done_force = '0;
    int           iter_seq = 0;
    int           cyc = 0;

    always @(posedge clock) cyc++;

    // Monitor: scoreboard, grant reference model and latency check.
    always @(negedge clock) begin
        logic [N-1:0] exp_g;
        node_t        e, got;
        int           idx;
        if (reset) begin
            xm      = '0;
            prev_xm = '0;
        end else begin
            if (prev_xm != '0 && !prev_abort) begin
                checks++;
                if (g_valid !== 1'b1 || g_node_id !== prev_id) begin
                    errors++;
                    $display("FAIL lag: g_valid=%0b g_node_id=%0h, required 1/%0h", g_valid, g_node_id, prev_id);
                end
            end
            if (g_valid && g_ready) begin
                checks++;
                rcv_cnt++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL gather_extra: got id %0h with empty scoreboard", g_node_id);
                end else begin
                    e = sb.pop_front();
                    if (g_node_id !== e.id || g_value !== e.value) begin
                        errors++;
                        $display("FAIL gather_data: got %0h/%0h, required %0h/%0h", g_node_id, g_value, e.id, e.value);
                    end
                end
            end
            if (g_valid && !g_ready) begin
                checks++;
                if (sc_ready !== '0) begin
                    errors++;
                    $display("FAIL stall_ready: sc_ready=%b, required 0", sc_ready);
                end
            end
            if (sc_ready != '0) begin
                exp_g = '0;
                for (int k = 0; k < N; k++) begin
                    automatic int p = (tb_ptr + k) % N;
                    if (sc_valid[p]) begin
                        exp_g[p] = 1'b1;
                        break;
                    end
                end
                checks++;
                if (sc_ready !== exp_g) begin
                    errors++;
                    $display("FAIL rr_grant: sc_ready=%b, required %b (ptr %0d)", sc_ready, exp_g, tb_ptr);
                end
            end
            xm = sc_valid & sc_ready;
            if (xm != '0) begin
                idx = 0;
                for (int i = 0; i < N; i++) if (xm[i]) idx = i;
                got.id    = sc_node_id[idx];
                got.value = sc_value[idx];
                sb.push_back(got);
                prev_id = sc_node_id[idx];
                tb_ptr  = (idx + 1) % N;
                grant_log.push_back(idx);
                grant_cyc.push_back(cyc);
            end
            prev_xm    = xm;
            prev_abort = abort;
            if (sc_next_iter != '0) begin
                launch_cnt++;
                launch_seen = 1'b1;
                checks++;
                if (sc_next_iter !== '1) begin
                    errors++;
                    $display("FAIL next_iter: %b, required all ones", sc_next_iter);
                end
            end
        end
    end

    // Scatter-unit models: pop on accepted transfers, refill on launch in auto mode.
    always @(posedge clock) begin
        #1;
        for (int i = 0; i < N; i++)
            if (xm[i] && unit_q[i].size() != 0) void'(unit_q[i].pop_front());
        xm = '0;
        if (launch_seen && auto_mode) begin
            for (int i = 0; i < N; i++)
                for (int k = 0; k < 2; k++) begin
                    node_t n;
                    n.id    = 32'h1000 + iter_seq * 256 + i * 16 + k;
                    n.value = {32'hCAFE_0000 + 32'(iter_seq), 32'(i * 16 + k)};
                    unit_q[i].push_back(n);
                end
            iter_seq++;
        end
        launch_seen = 1'b0;
        for (int i = 0; i < N; i++) begin
            sc_valid[i] = (unit_q[i].size() != 0);
            if (unit_q[i].size() != 0) begin
                sc_node_id[i] = unit_q[i][0].id;
                sc_value[i]   = unit_q[i][0].value;
            end
            sc_done[i] = done_force[i] | (auto_mode && unit_q[i].size() == 0);
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic cleanup();
        for (int i = 0; i < N; i++) unit_q[i].delete();
        sb.delete();
        done_force  = '0;
        auto_mode   = 1'b0;
        g_ready     = 1'b1;
        gather_idle = 1'b1;
        rcv_cnt     = 0;
        launch_cnt  = 0;
        tick();
    endtask

    task automatic load_unit(input int u, input int cnt, input int base);
        for (int k = 0; k < cnt; k++) begin
            node_t n;
            n.id    = 32'(base + u * 16 + k);
            n.value = {32'(base), 32'hBEEF_0000 + 32'(u * 16 + k)};
            unit_q[u].push_back(n);
        end
    endtask

    task automatic wait_run_done(input string what);
        int n = 0;
        while (!run_done && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (!run_done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: run_done=0 after %0d cycles", what, n);
        end
    endtask

    task automatic wait_g_valid(input string what);
        int n = 0;
        @(negedge clock);
        while (!g_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!g_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_gvalid_timeout: g_valid never rose", what);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if ({busy, run_done, g_valid, iter_count, sc_enable, sc_next_iter, sc_ready, stat_xfers, stat_stalls} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%0b run_done=%0b g_valid=%0b iter=%0d en=%b, required all 0",
                     busy, run_done, g_valid, iter_count, sc_enable);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        load_unit(0, 3, 'h500);
        load_unit(1, 3, 'h500);
        g_ready      = 1'b0;
        cfg_max_iter = 8'd1;
        pulse_start();
        wait_g_valid("reset_mid");
        tick();
        reset = 1'b1;
        for (int i = 0; i < N; i++) unit_q[i].delete();
        sb.delete();
        tb_ptr = 0;
        #1;
        checks++;
        if ({busy, run_done, g_valid, iter_count, sc_enable, sc_ready} !== '0 || dut.state !== IDLE) begin
            errors++;
            $display("FAIL reset_mid_async: busy=%0b g_valid=%0b en=%b state=%0d, required 0/0/0/IDLE",
                     busy, g_valid, sc_enable, dut.state);
        end
        @(negedge clock);
        checks++;
        if ({busy, g_valid, g_node_id, g_value, sc_enable} !== '0 || dut.state !== IDLE) begin
            errors++;
            $display("FAIL reset_mid_edge: busy=%0b g_valid=%0b id=%0h, required 0", busy, g_valid, g_node_id);
        end
        tick();
        reset = 1'b0;
        cleanup();
    endtask

    task automatic test_round_robin();
        int n = 0;
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) load_unit(i, 2, 'h100);
        grant_log.delete();
        grant_cyc.delete();
        cfg_max_iter = 8'd1;
        pulse_start();
        while (rcv_cnt < 8 && n < 100) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (rcv_cnt != 8 || grant_log.size() != 8) begin
            errors++;
            $display("FAIL rr_count: received %0d grants %0d, required 8/8", rcv_cnt, grant_log.size());
        end
        for (int k = 0; k < 5 && k < grant_log.size(); k++) begin
            checks++;
            if (grant_log[k] != exp_seq[k]) begin
                errors++;
                $display("FAIL rr_order[%0d]: grant %0d, required %0d", k, grant_log[k], exp_seq[k]);
            end
        end
        if (grant_cyc.size() >= 5) begin
            checks++;
            if (grant_cyc[4] - grant_cyc[0] != 4) begin
                errors++;
                $display("FAIL rr_back_to_back: 5 grants over %0d cycles, required 4", grant_cyc[4] - grant_cyc[0]);
            end
        end
        done_force = '1;
        wait_run_done("rr");
        checks++;
        if (iter_count !== 8'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_iter: iter_count=%0d busy=%0b, required 1/0", iter_count, busy);
        end
        cleanup();
    endtask

    task automatic test_backpressure();
        logic [ID_W-1:0]  id0;
        logic [VAL_W-1:0] val0;
        int n = 0;
        for (int i = 0; i < N; i++) load_unit(i, 2, 'h200);
        g_ready      = 1'b0;
        cfg_max_iter = 8'd1;
        pulse_start();
        wait_g_valid("bp");
        id0  = g_node_id;
        val0 = g_value;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clock);
            checks++;
            if (g_valid !== 1'b1 || g_node_id !== id0 || g_value !== val0 || sc_ready !== '0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: g_valid=%0b id=%0h ready=%b, required 1/%0h/0", k, g_valid, g_node_id, sc_ready, id0);
            end
        end
        @(posedge clock);
        #1;
        g_ready = 1'b1;
        while (rcv_cnt < 8 && n < 100) begin
            @(negedge clock);
            n++;
        end
        done_force = '1;
        wait_run_done("bp");
        checks++;
`ifdef PR_SCHED_STATS_EN
        if (stat_stalls !== 32'd5 || stat_xfers !== 32'd8) begin
            errors++;
            $display("FAIL bp_stats: stalls=%0d xfers=%0d, required 5/8", stat_stalls, stat_xfers);
        end
`else
        if (stat_stalls !== 32'd0 || stat_xfers !== 32'd0) begin
            errors++;
            $display("FAIL bp_stats: stalls=%0d xfers=%0d, required 0/0", stat_stalls, stat_xfers);
        end
`endif
        cleanup();
    endtask

    task automatic test_iteration_flow();
        auto_mode    = 1'b1;
        gather_idle  = 1'b0;
        cfg_max_iter = 8'd3;
        pulse_start();
        for (int it = 1; it <= 3; it++) begin
            int n = 0;
            while (rcv_cnt < 8 * it && n < 200) begin
                @(negedge clock);
                n++;
            end
            repeat (6) @(negedge clock);
            checks++;
            if (rcv_cnt != 8 * it || iter_count !== ITER_W'(it - 1) || busy !== 1'b1) begin
                errors++;
                $display("FAIL flow_drain_wait[%0d]: rcv=%0d iter=%0d busy=%0b, required %0d/%0d/1",
                         it, rcv_cnt, iter_count, busy, 8 * it, it - 1);
            end
            tick();
            gather_idle = 1'b1;
            n = 0;
            while (iter_count != ITER_W'(it) && n < 20) begin
                @(negedge clock);
                n++;
            end
            checks++;
            if (iter_count !== ITER_W'(it)) begin
                errors++;
                $display("FAIL flow_iter[%0d]: iter_count=%0d, required %0d", it, iter_count, it);
            end
            tick();
            gather_idle = 1'b0;
        end
        gather_idle = 1'b1;
        wait_run_done("flow");
        checks++;
        if (launch_cnt != 3 || rcv_cnt != 24 || iter_count !== 8'd3 || sb.size() != 0) begin
            errors++;
            $display("FAIL flow_summary: launches=%0d rcv=%0d iter=%0d sb=%0d, required 3/24/3/0",
                     launch_cnt, rcv_cnt, iter_count, sb.size());
        end
        cleanup();
    endtask

    task automatic test_edge_config();
        auto_mode    = 1'b1;
        cfg_max_iter = 8'd0;
        pulse_start();
        repeat (3) tick();
        cfg_max_iter = 8'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_run_done("edge");
        repeat (4) @(negedge clock);
        checks++;
        if (iter_count !== 8'd1 || launch_cnt != 1 || run_done !== 1'b1 || rcv_cnt != 8) begin
            errors++;
            $display("FAIL edge_one_iter: iter=%0d launches=%0d run_done=%0b rcv=%0d, required 1/1/1/8",
                     iter_count, launch_cnt, run_done, rcv_cnt);
        end
        cleanup();
    endtask

    task automatic test_abort();
        int lc;
        auto_mode    = 1'b1;
        g_ready      = 1'b0;
        cfg_max_iter = 8'd3;
        pulse_start();
        wait_g_valid("abort");
        tick();
        abort = 1'b1;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (run_done !== 1'b1 || busy !== 1'b0 || g_valid !== 1'b0 || sc_enable !== '0 || iter_count !== 8'd0) begin
            errors++;
            $display("FAIL abort_done: run_done=%0b busy=%0b g_valid=%0b iter=%0d, required 1/0/0/0",
                     run_done, busy, g_valid, iter_count);
        end
        lc = launch_cnt;
        start = 1'b1;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (run_done !== 1'b1 || busy !== 1'b0 || launch_cnt != lc) begin
            errors++;
            $display("FAIL abort_beats_start: run_done=%0b busy=%0b launches=%0d, required 1/0/%0d",
                     run_done, busy, launch_cnt, lc);
        end
        start = 1'b0;
        abort = 1'b0;
        sb.delete();
        cleanup();
    endtask

    task automatic test_early_done();
        load_unit(2, 3, 'h700);
        done_force   = '1;
        cfg_max_iter = 8'd1;
        pulse_start();
        wait_run_done("early");
        checks++;
        if (rcv_cnt != 3 || sb.size() != 0 || unit_q[2].size() != 0) begin
            errors++;
            $display("FAIL early_done: rcv=%0d sb=%0d left=%0d, required 3/0/0", rcv_cnt, sb.size(), unit_q[2].size());
        end
        cleanup();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_mid();
        test_round_robin();
        test_backpressure();
        test_iteration_flow();
        test_edge_config();
        test_abort();
        test_early_done();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
